// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute control for a small core with a hardware
// return-address stack. It walks the program counter and fetches opcodes.
// It drives the stack's push/pop/clear strobes and keeps a shadow depth count.
// The shadow count lets a bad CALL or RET halt the core before the stack
// itself is touched.
module pc_sequencer #(
    parameter int PC_WIDTH     = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int STACK_DEPTH  = 16,
    parameter logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(0),
    parameter logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(1),
    parameter logic [OPCODE_WIDTH-1:0] OP_JZ    = OPCODE_WIDTH'(2),
    parameter logic [OPCODE_WIDTH-1:0] OP_CALL  = OPCODE_WIDTH'(3),
    parameter logic [OPCODE_WIDTH-1:0] OP_RET   = OPCODE_WIDTH'(4),
    parameter logic [OPCODE_WIDTH-1:0] OP_RESET = OPCODE_WIDTH'(5),
    parameter logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(6)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               instr_valid,
    input  logic [OPCODE_WIDTH-1:0]            opcode,
    input  logic [PC_WIDTH-1:0]                operand,
    input  logic                               zero_flag,
    input  logic [PC_WIDTH-1:0]                return_to,
    output logic [PC_WIDTH-1:0]                pc,
    output logic                               fetch_req,
    output logic                               call,
    output logic                               ret,
    output logic                               stack_clear,
    output logic [PC_WIDTH-1:0]                called_from,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               halted,
    output logic                               stack_error
);

    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_FULL = DEPTH_WIDTH'(STACK_DEPTH);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]              state_reg,  state_next;
    logic [PC_WIDTH-1:0]     pc_reg,     pc_next;
    logic [DEPTH_WIDTH-1:0]  depth_reg,  depth_next;
    logic                    error_reg,  error_next;
    logic [OPCODE_WIDTH-1:0] ir_op_reg;
    logic [PC_WIDTH-1:0]     ir_operand_reg;

    logic                    in_exec;
    logic                    can_push;
    logic                    can_pop;
    logic                    do_call;
    logic                    do_ret;
    logic                    do_clear;
    logic [PC_WIDTH-1:0]     pc_inc;

    // Decode the latched instruction into the stack actions it is allowed to take
    always_comb begin
        in_exec  = (state_reg == ST_EXEC);
        can_push = (depth_reg < DEPTH_FULL);
        can_pop  = (depth_reg != '0);
        do_call  = in_exec && (ir_op_reg == OP_CALL) && can_push;
        do_ret   = in_exec && (ir_op_reg == OP_RET) && can_pop;
        do_clear = (state_reg == ST_INIT) || (in_exec && (ir_op_reg == OP_RESET));
        pc_inc   = pc_reg + PC_WIDTH'(1);
    end

    // Next-state, next-PC and shadow depth bookkeeping
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        depth_next = depth_reg;
        error_next = error_reg;
        case (state_reg)
            ST_INIT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                case (ir_op_reg)
                    OP_JMP: begin
                        pc_next = ir_operand_reg;
                    end
                    OP_JZ: begin
                        pc_next = zero_flag ? ir_operand_reg : pc_inc;
                    end
                    OP_CALL: begin
                        if (can_push) begin
                            depth_next = depth_reg + DEPTH_WIDTH'(1);
                            pc_next    = ir_operand_reg;
                        end else begin
                            // Overflow: leave the stack alone and stop at the offending CALL
                            error_next = 1'b1;
                            state_next = ST_HALT;
                        end
                    end
                    OP_RET: begin
                        if (can_pop) begin
                            depth_next = depth_reg - DEPTH_WIDTH'(1);
                            pc_next    = return_to;
                        end else begin
                            // Underflow: nothing to return to, stop at the RET
                            error_next = 1'b1;
                            state_next = ST_HALT;
                        end
                    end
                    OP_RESET: begin
                        depth_next = '0;
                        pc_next    = '0;
                    end
                    OP_HALT: begin
                        state_next = ST_HALT;
                    end
                    default: begin
                        // NOP and any unassigned opcode just advance
                        pc_next = pc_inc;
                    end
                endcase
            end
            default: begin
                // HALT is left only through reset
                state_next = ST_HALT;
            end
        endcase
    end

    // Architectural state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_INIT;
            pc_reg    <= '0;
            depth_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            depth_reg <= depth_next;
            error_reg <= error_next;
        end
    end

    // Instruction register: captured on the accepting FETCH cycle only
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_op_reg      <= OP_NOP;
            ir_operand_reg <= '0;
        end else if ((state_reg == ST_FETCH) && instr_valid) begin
            ir_op_reg      <= opcode;
            ir_operand_reg <= operand;
        end
    end

    // Outputs; strobes are suppressed while reset is asserted so a pending
    // CALL/RET in EXEC never reaches the stack on the reset cycle
    always_comb begin
        pc          = pc_reg;
        depth       = depth_reg;
        stack_error = error_reg;
        fetch_req   = !reset && (state_reg == ST_FETCH);
        halted      = !reset && (state_reg == ST_HALT);
        call        = !reset && do_call;
        ret         = !reset && do_ret;
        stack_clear = !reset && do_clear;
        called_from = (!reset && do_call) ? pc_reg : '0;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a vector table of instructions with expected
// strobes and post-EXEC state, pushed through a scoreboard queue, plus
// hand-written sequences for reset, halt, stall and stack-limit cases.
module tb_pc_sequencer;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_JMP   = 4'd1;
    localparam logic [3:0] OP_JZ    = 4'd2;
    localparam logic [3:0] OP_CALL  = 4'd3;
    localparam logic [3:0] OP_RET   = 4'd4;
    localparam logic [3:0] OP_RESET = 4'd5;
    localparam logic [3:0] OP_HALT  = 4'd6;

    typedef struct {
        logic [3:0] op;
        logic [7:0] operand;
        logic       zf;
        logic [7:0] rt;
        logic       e_call;
        logic       e_ret;
        logic       e_clear;
        logic [7:0] e_cf;
        logic [7:0] e_pc;
        logic [4:0] e_depth;
        logic       e_halted;
        logic       e_err;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic [7:0] operand = 8'd0;
    logic       zero_flag = 1'b0;
    logic [7:0] return_to = 8'd0;
    logic [7:0] pc;
    logic       fetch_req;
    logic       call;
    logic       ret;
    logic       stack_clear;
    logic [7:0] called_from;
    logic [4:0] depth;
    logic       halted;
    logic       stack_error;

    int   tests = 0;
    int   fails = 0;
    vec_t sb[$];
    vec_t tbl[16];

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand     (operand),
        .zero_flag   (zero_flag),
        .return_to   (return_to),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .call        (call),
        .ret         (ret),
        .stack_clear (stack_clear),
        .called_from (called_from),
        .depth       (depth),
        .halted      (halted),
        .stack_error (stack_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] opd, input logic zf,
                                input logic [7:0] rt, input logic c, input logic r,
                                input logic cl, input logic [7:0] cf, input logic [7:0] npc,
                                input logic [4:0] d, input logic h, input logic e);
        vec_t v;
        v.op = op; v.operand = opd; v.zf = zf; v.rt = rt;
        v.e_call = c; v.e_ret = r; v.e_clear = cl; v.e_cf = cf;
        v.e_pc = npc; v.e_depth = d; v.e_halted = h; v.e_err = e;
        return v;
    endfunction

    // Reset for one edge, check the reset state, then the INIT clear pulse and FETCH
    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_err", 32'(stack_error), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fetch", 32'(fetch_req), 32'h0);
        chk("rst_strobes", 32'({call, ret, stack_clear}), 32'h0);
        chk("rst_cf", 32'(called_from), 32'h0);
        reset = 1'b0;
        #1;
        chk("init_clear", 32'(stack_clear), 32'h1);
        chk("init_fetch", 32'(fetch_req), 32'h0);
        @(posedge clock); #1;
        chk("fetch_clear", 32'(stack_clear), 32'h0);
        chk("fetch_req", 32'(fetch_req), 32'h1);
        $display("[TB] reset done pc=%02h depth=%0d err=%0b", pc, depth, stack_error);
    endtask

    // Present one instruction in FETCH, check EXEC strobes, then post-EXEC state
    task automatic run_instr(input vec_t v, input int idx);
        vec_t e;
        int   n;
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("fetch_wait", 32'(fetch_req), 32'h1);
        opcode      = v.op;
        operand     = v.operand;
        zero_flag   = v.zf;
        return_to   = v.rt;
        instr_valid = 1'b1;
        sb.push_back(v);
        @(posedge clock); #1;
        instr_valid = 1'b0;
        e = sb.pop_front();
        chk("exec_call", 32'(call), 32'(e.e_call));
        chk("exec_ret", 32'(ret), 32'(e.e_ret));
        chk("exec_clear", 32'(stack_clear), 32'(e.e_clear));
        if (e.e_call) chk("exec_called_from", 32'(called_from), 32'(e.e_cf));
        @(posedge clock); #1;
        chk("post_pc", 32'(pc), 32'(e.e_pc));
        chk("post_depth", 32'(depth), 32'(e.e_depth));
        chk("post_halted", 32'(halted), 32'(e.e_halted));
        chk("post_err", 32'(stack_error), 32'(e.e_err));
        $display("[TB] instr %0d op=%0d opd=%02h -> pc=%02h depth=%0d halted=%0b err=%0b",
                 idx, v.op, v.operand, pc, depth, halted, stack_error);
    endtask

    initial begin
        logic [7:0] prev_pc;
        logic [7:0] tgt;

        //              op        opd    zf    rt     c     r     cl    cf     pc     d     h     e
        tbl[0]  = mk(OP_NOP,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 5'd0, 1'b0, 1'b0);
        tbl[1]  = mk(OP_NOP,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 5'd0, 1'b0, 1'b0);
        tbl[2]  = mk(OP_NOP,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 5'd0, 1'b0, 1'b0);
        tbl[3]  = mk(OP_JMP,   8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 5'd0, 1'b0, 1'b0);
        tbl[4]  = mk(OP_JZ,    8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h06, 5'd0, 1'b0, 1'b0);
        tbl[5]  = mk(OP_JMP,   8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, 5'd0, 1'b0, 1'b0);
        tbl[6]  = mk(OP_JZ,    8'h20, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 5'd0, 1'b0, 1'b0);
        tbl[7]  = mk(OP_JMP,   8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 5'd0, 1'b0, 1'b0);
        tbl[8]  = mk(OP_CALL,  8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 8'h40, 5'd1, 1'b0, 1'b0);
        tbl[9]  = mk(OP_RET,   8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 5'd0, 1'b0, 1'b0);
        tbl[10] = mk(4'hF,     8'h99, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 5'd0, 1'b0, 1'b0);
        tbl[11] = mk(OP_JMP,   8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 5'd0, 1'b0, 1'b0);
        tbl[12] = mk(OP_NOP,   8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
        tbl[13] = mk(OP_CALL,  8'h30, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h30, 5'd1, 1'b0, 1'b0);
        tbl[14] = mk(OP_RESET, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0);
        tbl[15] = mk(OP_RET,   8'h00, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 1'b1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i], i);
        end

        // Underflow left the core halted: nothing fetched, pc frozen
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("halt_fetch", 32'(fetch_req), 32'h0);
            chk("halt_flag", 32'(halted), 32'h1);
            chk("halt_pc", 32'(pc), 32'h0);
        end
        $display("[TB] halted after underflow pc=%02h err=%0b", pc, stack_error);

        // Reset clears the sticky error and replays INIT
        do_reset();

        // FETCH waits indefinitely for instr_valid
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("stall_pc", 32'(pc), 32'h0);
            chk("stall_fetch", 32'(fetch_req), 32'h1);
        end
        $display("[TB] fetch stall 5 cycles pc=%02h", pc);
        run_instr(mk(OP_NOP,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 5'd0, 1'b0, 1'b0), 100);
        run_instr(mk(OP_HALT, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 5'd0, 1'b1, 1'b0), 101);

        // Sixteen nested CALLs fill the stack, the seventeenth overflows
        do_reset();
        prev_pc = 8'h00;
        for (int k = 0; k < 16; k++) begin
            tgt = 8'h20 + 8'(k);
            run_instr(mk(OP_CALL, tgt, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, prev_pc, tgt,
                         5'(k + 1), 1'b0, 1'b0), 200 + k);
            prev_pc = tgt;
        end
        run_instr(mk(OP_CALL, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h2F,
                     5'd16, 1'b1, 1'b1), 216);

        // Reset arriving during EXEC of a CALL suppresses the push
        do_reset();
        run_instr(mk(OP_JMP, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h33, 5'd0, 1'b0, 1'b0), 300);
        opcode = OP_CALL;
        operand = 8'h40;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        chk("pre_rst_call", 32'(call), 32'h1);
        chk("pre_rst_cf", 32'(called_from), 32'h33);
        reset = 1'b1;
        #1;
        chk("rst_exec_call", 32'(call), 32'h0);
        chk("rst_exec_cf", 32'(called_from), 32'h0);
        @(posedge clock); #1;
        chk("rst_exec_pc", 32'(pc), 32'h0);
        chk("rst_exec_depth", 32'(depth), 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_exec_init_clear", 32'(stack_clear), 32'h1);
        @(posedge clock); #1;
        chk("rst_exec_fetch", 32'(fetch_req), 32'h1);
        $display("[TB] reset during CALL exec pc=%02h depth=%0d", pc, depth);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control-side counterpart of the return-address stack: fetches opcodes, computes the next PC, and drives the stack's push/pop/clear strobes.
- Consumes the stack's combinational top-of-stack (return_to) on RET.
- Keeps a shadow depth counter so stack overflow and underflow are caught before they corrupt the stack.
- Sits between instruction memory and the return stack in the CPU core.

Parameters:
- PC_WIDTH, 8, program counter and address width.
- OPCODE_WIDTH, 4, opcode field width.
- STACK_DEPTH, 16, number of return-stack entries.
- OP_NOP, 0, no operation.
- OP_JMP, 1, unconditional jump to operand.
- OP_JZ, 2, jump to operand if zero_flag.
- OP_CALL, 3, push return address, jump to operand.
- OP_RET, 4, pop, jump to return_to.
- OP_RESET, 5, clear stack, PC to 0.
- OP_HALT, 6, stop fetching.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction memory holds valid opcode/operand for address pc.
- opcode  in  OPCODE_WIDTH  fetched opcode.
- operand  in  PC_WIDTH  jump/call target.
- zero_flag  in  1  ALU zero flag, sampled in EXEC.
- return_to  in  PC_WIDTH  top-of-stack from return stack (already return address, i.e. call site + 1).
- pc  out  PC_WIDTH  current fetch address.
- fetch_req  out  1  request instruction at pc.
- call  out  1  one-cycle push strobe.
- ret  out  1  one-cycle pop strobe.
- stack_clear  out  1  one-cycle clear strobe.
- called_from  out  PC_WIDTH  address of the CALL instruction; the stack stores called_from+1.
- depth  out  clog2(STACK_DEPTH+1)  shadow occupancy.
- halted  out  1  in HALT state.
- stack_error  out  1  sticky over/underflow flag.

Behaviour:
- Reset (reset=1 at posedge):
  - state<=INIT; pc<=0; depth<=0; stack_error<=0.
  - All strobes 0, fetch_req 0, halted 0, called_from 0.
  - Reset overrides everything, including mid-EXEC.
  - No strobe is emitted in the cycle reset is sampled.
- States: INIT, FETCH, EXEC, HALT.
- INIT:
  - stack_clear=1 for exactly one cycle.
  - Then go to FETCH.
- FETCH:
  - fetch_req=1; pc stable.
  - On instr_valid=1: latch opcode/operand into ir registers, go to EXEC.
  - Otherwise stay (unbounded wait).
- EXEC (one cycle; strobes are combinational from latched ir and valid only in this cycle):
  - NOP: pc<=pc+1.
  - JMP: pc<=operand.
  - JZ: pc<=operand if zero_flag else pc+1.
  - CALL with depth<STACK_DEPTH: call=1, called_from=pc, depth<=depth+1, pc<=operand.
  - RET with depth>0: ret=1, pc<=return_to (top-of-stack sampled before the pop takes effect), depth<=depth-1.
  - RESET: stack_clear=1, depth<=0, pc<=0.
  - HALT: go to HALT, pc unchanged.
  - Undefined opcode: treated as NOP.
  - Next state is FETCH except for HALT or an error.
- Overflow (CALL at depth==STACK_DEPTH) and underflow (RET at depth==0):
  - No strobe; stack_error<=1; go to HALT; pc unchanged.
- HALT:
  - halted=1, fetch_req=0.
  - Exit only via reset.
- Arithmetic:
  - pc+1 wraps modulo 2^PC_WIDTH (0xFF -> 0x00).
  - depth never wraps.
- Exclusivity: call, ret and stack_clear are mutually exclusive and never high outside EXEC/INIT.
- Throughput: 2 cycles per instruction minimum (FETCH+EXEC); instr_valid during EXEC is ignored.

Test Plan:
- Reset then instr_valid held 1 with NOP stream -> stack_clear pulse in cycle 1; pc reaches 0,1,2,3 on every second cycle; at pc=0xFF, NOP -> pc=0x00.
- At pc=0x10, CALL 0x40, then RET at 0x40 with return_to driven 0x11 -> call=1 and called_from=0x10 in EXEC; pc=0x40, depth=1; then ret=1, pc=0x11, depth=0.
- 16 nested CALLs then a 17th -> depth=16, 17th gives no call strobe, stack_error=1, halted=1, pc holds 17th CALL address.
- RET at depth 0 -> ret=0, stack_error=1, halted=1; asserting reset -> stack_error=0, state INIT, stack_clear pulse.
- JZ 0x20 at pc=0x05 with zero_flag=0, then same with zero_flag=1 -> pc=0x06, then pc=0x20; instr_valid held 0 for 5 cycles in FETCH -> pc and state unchanged.
- Reset asserted during EXEC of a CALL -> no call strobe that cycle, depth=0, pc=0.
